// File: rtl/reg_bank_loader.sv
// reg_bank_loader: byte-stream frame to one-hot register write strobe; REG_BANK_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module reg_bank_loader #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [WIDTH-1:0]  D,
  output logic [NREGS-1:0]  CE,
  output logic              ERR,
  output logic              BUSY
);
  localparam int NB = WIDTH / 8;
  typedef enum logic [1:0] {IDLE, DATA, CHK, COMMIT} state_t;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = COMMIT;
`endif
  state_t            state, nxt;
  logic [ADDR_W-1:0] addr;
  logic              bad;
  logic [3:0]        cnt;
  logic [WIDTH-1:0]  asm_q, asm_n, d_fin;
  logic              take, last, fin, rej;
  assign take  = IN_VALID && IN_READY;
  assign last  = cnt == 4'(NB - 1);
  assign asm_n = (asm_q << 8) | WIDTH'(IN_DATA);
  assign fin   = take && nxt == COMMIT;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign d_fin = asm_q;
  assign rej   = bad || IN_DATA != csum;
`else
  assign d_fin = asm_n;
  assign rej   = bad;
`endif
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= nxt;
  // next state: frames advance only on accepted bytes, COMMIT is a single cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = take ? DATA : IDLE;
      DATA:    nxt = take && last ? AFTER_DATA : DATA;
      CHK:     nxt = take ? COMMIT : CHK;
      default: nxt = IDLE;
    endcase
  end
  // frame assembly, registered handshake/status and the commit strobe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IN_READY <= 1'b0;
      BUSY     <= 1'b0;
      D        <= '0;
      CE       <= '0;
      ERR      <= 1'b0;
      addr     <= '0;
      bad      <= 1'b0;
      cnt      <= '0;
      asm_q    <= '0;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      IN_READY <= nxt != COMMIT;
      BUSY     <= nxt != IDLE;
      CE       <= '0;
      ERR      <= 1'b0;
      if (take && state == IDLE) begin
        addr <= IN_DATA[ADDR_W-1:0];
        bad  <= 32'(IN_DATA[ADDR_W-1:0]) >= NREGS;
        cnt  <= '0;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
        csum <= IN_DATA;
`endif
      end
      if (take && state == DATA) begin
        asm_q <= asm_n;
        cnt   <= cnt + 4'd1;
`ifdef REG_BANK_LOADER_CHECKSUM_EN
        csum  <= csum ^ IN_DATA;
`endif
      end
      if (fin) begin
        ERR <= rej;
        CE  <= rej ? '0 : NREGS'(1) << addr;
        D   <= rej ? D : d_fin;
      end
    end
  end
endmodule

// File: doc/reg_bank_loader.md
# reg_bank_loader

Write-side controller for a bank of chip-enabled N-bit registers. Accepts a byte-stream frame (address byte, then data bytes MSB first) over a valid/ready handshake, assembles the register value, and issues a single-cycle one-hot write strobe with the data bus to the addressed register. Sits between a host byte link (UART/SPI deserializer) and the register bank, driving each register's D and CE inputs.

## Interface
- WIDTH, 8: register width in bits; must be a multiple of 8, range 8..64.
- NREGS, 16: number of registers in the bank, range 1..256.
- ADDR_W, 8: address field width taken from the address byte (low ADDR_W bits), range 1..8.
- Clocking: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active high.
- IN_DATA  in  8  incoming frame byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a byte; a transfer occurs on a rising edge with IN_VALID && IN_READY.
- D  out  WIDTH  write data to all registers; registered.
- CE  out  NREGS  one-hot write strobe; bit i enables register i.
- ERR  out  1  single-cycle pulse when a frame is rejected.
- BUSY  out  1  high from address-byte acceptance through the commit cycle.

## Operation
- Frame layout: 1 address byte, then NB = WIDTH/8 data bytes, most-significant byte first. With the checksum feature, 1 additional trailing checksum byte follows.
- States:
  - IDLE: waiting for the address byte. Accept -> latch addr = IN_DATA[ADDR_W-1:0], set bad = (addr >= NREGS), clear the byte counter, go to DATA.
  - DATA: each accepted byte is shifted into the assembly register (shift left 8, OR in the byte); the counter increments. After the NB-th byte -> COMMIT, or -> CHK when the checksum feature is enabled.
  - CHK: one byte is accepted and compared; go to COMMIT.
  - COMMIT: lasts one cycle with IN_READY low, then returns to IDLE.
- Commit behaviour:
  - If the frame is valid: D <= assembled value and CE <= one-hot(addr), both for the COMMIT cycle. D holds its value afterwards until the next valid commit.
  - If bad (address out of range or checksum mismatch): CE stays 0, ERR pulses, D is unchanged.
- Rejected frames are always consumed to full length, so framing stays aligned.
- CE is never multi-hot and never asserted outside COMMIT.
- Reset mid-frame discards the partial frame. No CE or ERR is produced for it.
- Reset values: IN_READY=0, D=0, CE=0, ERR=0, BUSY=0, state=IDLE.

## Timing
- IN_READY is registered. After RST deasserts, it rises on the first rising CLK edge. It is high in IDLE/DATA/CHK and low only in the COMMIT cycle.
- Latency: the last frame byte is accepted at edge k. CE/ERR are high for the cycle between edges k and k+1. IN_READY is low in that same cycle and high again after edge k+1, so the next address byte can be accepted at edge k+2.
- Back-to-back throughput: (1 + NB [+1]) transfers + 1 cycle per frame.
- IN_VALID gaps (stalls) may occur between any bytes; there is no timeout, and state is held indefinitely.
- Whether IN_VALID is high or low during COMMIT, no byte is taken.
- BUSY is high from the edge after address acceptance to the end of COMMIT, inclusive.

## Configuration
- REG_BANK_LOADER_CHECKSUM_EN defined:
  - The frame carries a trailing checksum byte equal to the XOR of the address byte and all data bytes.
  - A mismatch rejects the frame with an ERR pulse and no CE.
  - Mismatch and bad address both produce a single ERR pulse.
- Undefined: there is no CHK state, the frame is 1+NB bytes, and only an out-of-range address causes ERR.

## Test plan
All scenarios use WIDTH=16, NREGS=4, ADDR_W=8.
- Basic write: bytes 0x02, 0xAB, 0xCD with IN_VALID held high -> one cycle with CE=4'b0100 and D=16'hABCD; ERR=0; then CE=0 with D held at 16'hABCD.
- Bad address: bytes 0x07, 0x12, 0x34 -> ERR pulses for one cycle, CE stays 0, D unchanged. The following frame 0x00, 0x55, 0xAA -> CE=4'b0001, D=16'h55AA.
- Stalls: frame 0x01, 0x12, 0x34 with IN_VALID low for 3 cycles between each byte -> CE=4'b0010 and D=16'h1234 exactly one cycle after the last byte; BUSY high throughout.
- Back-to-back frames 0x03, 0xDE, 0xAD then 0x01, 0xBE, 0xEF with IN_VALID always high -> IN_READY low for exactly one cycle between frames. Strobes: CE=4'b1000 with D=16'hDEAD, then CE=4'b0010 with D=16'hBEEF; no byte is lost.
- Reset mid-frame: send 0x02, 0x11, assert RST asynchronously, release, then send 0x01, 0x22, 0x33 -> no strobe for the aborted frame; CE=4'b0010 with D=16'h2233; all outputs 0 during reset.
- With REG_BANK_LOADER_CHECKSUM_EN:
  - Frame 0x02, 0xAB, 0xCD, 0x64 -> CE=4'b0100, D=16'hABCD.
  - Same frame with checksum 0x65 -> ERR pulse, CE=0.
